// File: rtl/reg_file.sv
// 16 x 8-bit general-purpose register file: two combinational read ports and
// one synchronous write port. Writes are frozen while the CPU is paused.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              we,
  input  logic              cpu_paused,
  output logic [DATA_W-1:0] read_a,
  output logic [DATA_W-1:0] read_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Reset wins over a write in the same cycle; a pause blocks the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && !cpu_paused) begin
      regs[wa] <= wd;
    end
  end

  // No write-to-read bypass: reads always reflect the stored contents.
  always_comb begin
    read_a = regs[ra];
    read_b = regs[rb];
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against a plain array model of the register contents.
module tb_reg_file;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] ra = '0;
  logic [ADDR_W-1:0] rb = '0;
  logic [ADDR_W-1:0] wa = '0;
  logic [DATA_W-1:0] wd = '0;
  logic              we = 1'b0;
  logic              cpu_paused = 1'b0;
  logic [DATA_W-1:0] read_a;
  logic [DATA_W-1:0] read_b;

  logic [DATA_W-1:0] model [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ra         (ra),
    .rb         (rb),
    .wa         (wa),
    .wd         (wd),
    .we         (we),
    .cpu_paused (cpu_paused),
    .read_a     (read_a),
    .read_b     (read_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // One rising edge; the model applies the architectural rules to the
  // inputs that were present at that edge.
  task automatic tick();
    logic              r_rst = rst;
    logic              r_we  = we;
    logic              r_pau = cpu_paused;
    logic [ADDR_W-1:0] r_wa  = wa;
    logic [DATA_W-1:0] r_wd  = wd;
    @(posedge clk);
    if (r_rst) begin
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    end else if (r_we && !r_pau) begin
      model[r_wa] = r_wd;
    end
    #1;
  endtask

  task automatic read_check(input string tag, input int a, input int b);
    @(negedge clk);
    ra = a[ADDR_W-1:0];
    rb = b[ADDR_W-1:0];
    #1;
    check({tag, "_a"}, read_a, model[a]);
    check({tag, "_b"}, read_b, model[b]);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 8'hXX;

    // 1: reset clears everything
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ra = i[ADDR_W-1:0];
      rb = i[ADDR_W-1:0];
      #1;
      check("reset_a", read_a, 8'h00);
      check("reset_b", read_b, 8'h00);
    end

    // 2: fill pattern i*0x11, then cross-sweep
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      we = 1'b1;
      wa = i[ADDR_W-1:0];
      wd = 8'(i * 8'h11);
      tick();
    end
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ra = i[ADDR_W-1:0];
      rb = 4'(15 - i);
      #1;
      check("fill_a", read_a, 8'(i * 8'h11));
      check("fill_b", read_b, 8'(( 15 - i) * 8'h11));
    end

    // 3: overwrite, same address on both ports
    @(negedge clk);
    we = 1'b1; wa = 4'd3; wd = 8'hAA;
    ra = 4'd3; rb = 4'd3;
    #1;
    check("no_bypass", read_a, 8'h33);
    tick();
    @(negedge clk);
    we = 1'b0;
    #1;
    check("overwrite_a", read_a, 8'hAA);
    check("overwrite_b", read_b, 8'hAA);

    // 4: write disabled
    @(negedge clk);
    we = 1'b0; wa = 4'd5; wd = 8'h11;
    tick();
    @(negedge clk);
    ra = 4'd5;
    #1;
    check("we_low", read_a, 8'h55);

    // 5: paused blocks writes; unpaused write lands
    @(negedge clk);
    cpu_paused = 1'b1; we = 1'b1; wa = 4'd7; wd = 8'h00;
    tick();
    @(negedge clk);
    ra = 4'd7;
    #1;
    check("paused", read_a, 8'h77);
    @(negedge clk);
    cpu_paused = 1'b0;
    tick();
    @(negedge clk);
    we = 1'b0;
    #1;
    check("unpaused", read_a, 8'h00);

    // 6: reset beats a simultaneous write
    @(negedge clk);
    rst = 1'b1; we = 1'b1; wa = 4'd2; wd = 8'hFF;
    tick();
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ra = i[ADDR_W-1:0];
      rb = 4'd2;
      #1;
      check("reset_mid_a", read_a, 8'h00);
      check("reset_mid_b", read_b, 8'h00);
    end

    // Randomized traffic; reads sampled before each edge see pre-write state
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 49) == 0);
      we         = ($urandom_range(0, 3) != 0);
      cpu_paused = ($urandom_range(0, 3) == 0);
      wa         = 4'($urandom_range(0, DEPTH - 1));
      wd         = 8'($urandom);
      ra         = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, DEPTH - 1));
      rb         = 4'($urandom_range(0, DEPTH - 1));
      #1;
      check("rand_a", read_a, model[ra]);
      check("rand_b", read_b, model[rb]);
      tick();
    end
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < DEPTH; i++) read_check("final", i, DEPTH - 1 - i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
